// File: rtl/bpred_pc_unit.sv
// rtl/bpred_pc_unit.sv - fetch PC register with BTB/2-bit prediction and EX branch resolution
module bpred_pc_unit #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [6:0]      ex_opcode_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic [XLEN-1:0] ex_link_o,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     mispredict_cnt_o
);
  localparam int              IDX  = $clog2(BTB_ENTRIES);
  localparam int              TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] r_fetch_pc;
  logic [31:0]     r_mis_cnt;
  logic            r_valid [BTB_ENTRIES];
  logic [TAGW-1:0] r_tag   [BTB_ENTRIES];
  logic [XLEN-1:0] r_tgt   [BTB_ENTRIES];
  logic [1:0]      r_ctr   [BTB_ENTRIES];

  logic [IDX-1:0]  w_f_idx, w_ex_idx;
  logic [TAGW-1:0] w_f_tag, w_ex_tag;
  logic            w_f_hit, w_ex_hit;
  logic            w_is_br, w_is_jal, w_is_jalr;
  logic            w_br_cond, w_taken;
  logic [XLEN-1:0] w_pc_imm, w_jalr_sum, w_target, w_ex_seq;

  assign w_f_idx  = r_fetch_pc[IDX+1:2];
  assign w_f_tag  = r_fetch_pc[XLEN-1:IDX+2];
  assign w_f_hit  = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_ex_idx = ex_pc_i[IDX+1:2];
  assign w_ex_tag = ex_pc_i[XLEN-1:IDX+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  assign fetch_pc_o       = r_fetch_pc;
  assign pred_taken_o     = w_f_hit && r_ctr[w_f_idx][1];
  assign pred_target_o    = pred_taken_o ? r_tgt[w_f_idx] : r_fetch_pc + FOUR;
  assign mispredict_cnt_o = r_mis_cnt;

  assign w_is_br    = (ex_opcode_i == 7'b1100011);
  assign w_is_jal   = (ex_opcode_i == 7'b1101111);
  assign w_is_jalr  = (ex_opcode_i == 7'b1100111);
  assign w_pc_imm   = ex_pc_i + ex_imm_i;
  assign w_jalr_sum = ex_rs1_i + ex_imm_i;
  assign w_ex_seq   = ex_pc_i + FOUR;

  always_comb begin
    w_br_cond = 1'b0;
    case (ex_funct3_i)
      3'd0:    w_br_cond = (ex_rs1_i == ex_rs2_i);
      3'd1:    w_br_cond = (ex_rs1_i != ex_rs2_i);
      3'd4:    w_br_cond = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
      3'd5:    w_br_cond = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
      3'd6:    w_br_cond = (ex_rs1_i <  ex_rs2_i);
      3'd7:    w_br_cond = (ex_rs1_i >= ex_rs2_i);
      default: w_br_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc_imm;
    if (w_is_br) begin
      w_taken = w_br_cond;
    end else if (w_is_jal) begin
      w_taken = 1'b1;
    end else if (w_is_jalr) begin
      w_taken  = 1'b1;
      w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign ex_link_o     = w_ex_seq;
  assign redirect_pc_o = w_taken ? w_target : w_ex_seq;
  assign flush_o       = ex_valid_i && !rst &&
                         ((w_taken != ex_pred_taken_i) ||
                          (w_taken && (w_target != ex_pred_target_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_mis_cnt  <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= 2'b01;
      end
    end else begin
      // A redirect must win over stall so the squashed path is never held.
      if (flush_o) begin
        r_fetch_pc <= redirect_pc_o;
        r_mis_cnt  <= r_mis_cnt + 32'd1;
      end else if (!stall_i) begin
        r_fetch_pc <= pred_target_o;
      end

      if (ex_valid_i) begin
        if (w_is_br) begin
          if (w_ex_hit) begin
            if (w_taken) begin
              r_tgt[w_ex_idx] <= w_target;
              if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            end else if (r_ctr[w_ex_idx] != 2'b00) begin
              r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
            end
          end else if (w_taken) begin
            r_valid[w_ex_idx] <= 1'b1;
            r_tag[w_ex_idx]   <= w_ex_tag;
            r_tgt[w_ex_idx]   <= w_target;
            r_ctr[w_ex_idx]   <= 2'b10;
          end
        end else if (w_is_jal || w_is_jalr) begin
          r_valid[w_ex_idx] <= 1'b1;
          r_tag[w_ex_idx]   <= w_ex_tag;
          r_tgt[w_ex_idx]   <= w_target;
          r_ctr[w_ex_idx]   <= 2'b11;
        end
      end
    end
  end
endmodule

// File: tb/tb_bpred_pc_unit.sv
// tb/tb_bpred_pc_unit.sv - scoreboard bench for bpred_pc_unit with directed vectors
module tb_bpred_pc_unit;
  logic        clk = 1'b0;
  logic        rst, stall_i;
  logic [31:0] fetch_pc_o, pred_target_o, ex_link_o, redirect_pc_o, mispredict_cnt_o;
  logic        pred_taken_o, flush_o;
  logic        ex_valid_i, ex_pred_taken_i;
  logic [6:0]  ex_opcode_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i, ex_rs1_i, ex_rs2_i, ex_imm_i, ex_pred_target_i;

  always #5 clk = ~clk;

  bpred_pc_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .fetch_pc_o(fetch_pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_opcode_i(ex_opcode_i), .ex_funct3_i(ex_funct3_i),
    .ex_pc_i(ex_pc_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_imm_i(ex_imm_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .ex_link_o(ex_link_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  localparam int S_PC = 0, S_PT = 1, S_PTGT = 2, S_FL = 3, S_RD = 4, S_LK = 5, S_CNT = 6;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_PC:    return fetch_pc_o;
      S_PT:    return {31'd0, pred_taken_o};
      S_PTGT:  return pred_target_o;
      S_FL:    return {31'd0, flush_o};
      S_RD:    return redirect_pc_o;
      S_LK:    return ex_link_o;
      default: return mispredict_cnt_o;
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.sel);
      n_checks++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.val, $time);
      end
    end
  end

  task automatic exp_push(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic ptk, input logic [31:0] ptgt);
    ex_valid_i = v; ex_opcode_i = op; ex_funct3_i = f3; ex_pc_i = pc;
    ex_rs1_i = rs1; ex_rs2_i = rs2; ex_imm_i = imm;
    ex_pred_taken_i = ptk; ex_pred_target_i = ptgt;
  endtask

  task automatic idle();
    ex_set(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    ex_set(1'b1, OP_JAL, 3'd0, 32'h10, 32'd0, 32'd0, 32'h20, 1'b0, 32'd0);
    step();
    exp_push("rst_pc", S_PC, 32'h0);
    exp_push("rst_pt", S_PT, 32'h0);
    exp_push("rst_ptgt", S_PTGT, 32'h4);
    exp_push("rst_flush", S_FL, 32'h0);
    exp_push("rst_cnt", S_CNT, 32'h0);
    step();
    rst = 1'b0; idle();
    exp_push("seq_pc0", S_PC, 32'h0);
    step();
    exp_push("seq_pc4", S_PC, 32'h4);
    step();
    exp_push("seq_pc8", S_PC, 32'h8);
    // BEQ cold miss, taken
    ex_set(1'b1, OP_BR, 3'd0, 32'h10, 32'd5, 32'd5, 32'h20, 1'b0, 32'd0);
    exp_push("beq_flush", S_FL, 32'h1);
    exp_push("beq_redir", S_RD, 32'h30);
    step();
    exp_push("beq_pc", S_PC, 32'h30);
    exp_push("beq_cnt", S_CNT, 32'h1);
    exp_push("pc30_pt", S_PT, 32'h0);
    // JAL back to 0x10
    ex_set(1'b1, OP_JAL, 3'd0, 32'h100, 32'd0, 32'd0, 32'hFFFF_FF10, 1'b0, 32'd0);
    exp_push("jal_flush", S_FL, 32'h1);
    exp_push("jal_redir", S_RD, 32'h10);
    exp_push("jal_link", S_LK, 32'h104);
    step();
    exp_push("pc10_pc", S_PC, 32'h10);
    exp_push("pc10_pt", S_PT, 32'h1);
    exp_push("pc10_ptgt", S_PTGT, 32'h30);
    exp_push("pc10_cnt", S_CNT, 32'h2);
    // BEQ at 0x10 not taken, predicted taken; lookup still sees pre-update entry
    ex_set(1'b1, OP_BR, 3'd0, 32'h10, 32'd5, 32'd6, 32'h20, 1'b1, 32'h30);
    exp_push("nt1_flush", S_FL, 32'h1);
    exp_push("nt1_redir", S_RD, 32'h14);
    step();
    exp_push("nt1_pc", S_PC, 32'h14);
    exp_push("nt1_cnt", S_CNT, 32'h3);
    ex_set(1'b1, OP_BR, 3'd0, 32'h10, 32'd5, 32'd6, 32'h20, 1'b0, 32'h0);
    exp_push("nt2_flush", S_FL, 32'h0);
    step();
    exp_push("nt2_pc", S_PC, 32'h18);
    exp_push("nt3_flush", S_FL, 32'h0);
    step();
    exp_push("nt3_pc", S_PC, 32'h1C);
    ex_set(1'b1, OP_JAL, 3'd0, 32'h100, 32'd0, 32'd0, 32'hFFFF_FF10, 1'b0, 32'd0);
    step();
    exp_push("sat_pc", S_PC, 32'h10);
    exp_push("sat_pt", S_PT, 32'h0);
    exp_push("sat_ptgt", S_PTGT, 32'h14);
    exp_push("sat_cnt", S_CNT, 32'h4);
    // JALR with matching prediction
    ex_set(1'b1, OP_JALR, 3'd0, 32'h40, 32'h101, 32'd0, 32'h4, 1'b1, 32'h104);
    exp_push("jalr_ok_flush", S_FL, 32'h0);
    exp_push("jalr_link", S_LK, 32'h44);
    exp_push("jalr_redir", S_RD, 32'h104);
    step();
    exp_push("jalr_pc", S_PC, 32'h14);
    ex_set(1'b1, OP_JALR, 3'd0, 32'h40, 32'h101, 32'd0, 32'h4, 1'b1, 32'h100);
    exp_push("jalr_bad_flush", S_FL, 32'h1);
    exp_push("jalr_bad_redir", S_RD, 32'h104);
    step();
    exp_push("jalr_bad_pc", S_PC, 32'h104);
    exp_push("jalr_bad_cnt", S_CNT, 32'h5);
    // Stall together with flush: flush wins
    stall_i = 1'b1;
    ex_set(1'b1, OP_BR, 3'd1, 32'h20, 32'd1, 32'd2, 32'hFFFF_FFF8, 1'b0, 32'd0);
    exp_push("bne_flush", S_FL, 32'h1);
    exp_push("bne_redir", S_RD, 32'h18);
    step();
    idle();
    exp_push("stflush_pc", S_PC, 32'h18);
    exp_push("stflush_cnt", S_CNT, 32'h6);
    step();
    stall_i = 1'b0;
    exp_push("stall_hold_pc", S_PC, 32'h18);
    step();
    exp_push("after_stall_pc", S_PC, 32'h1C);
    // BLT signed taken; allocates 0x50 over 0x10's index
    ex_set(1'b1, OP_BR, 3'd4, 32'h50, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h60);
    exp_push("blt_flush", S_FL, 32'h0);
    exp_push("blt_redir", S_RD, 32'h60);
    step();
    exp_push("pc20_pc", S_PC, 32'h20);
    exp_push("pc20_pt", S_PT, 32'h1);
    exp_push("pc20_ptgt", S_PTGT, 32'h18);
    ex_set(1'b1, OP_BR, 3'd6, 32'h50, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    exp_push("bltu_flush", S_FL, 32'h0);
    exp_push("bltu_redir", S_RD, 32'h54);
    step();
    exp_push("pred_pc", S_PC, 32'h18);
    ex_set(1'b1, OP_JAL, 3'd0, 32'h100, 32'd0, 32'd0, 32'hFFFF_FF10, 1'b0, 32'd0);
    step();
    exp_push("alias_pc", S_PC, 32'h10);
    exp_push("alias_pt", S_PT, 32'h0);
    exp_push("alias_ptgt", S_PTGT, 32'h14);
    exp_push("alias_cnt", S_CNT, 32'h7);
    // ex_valid_i low: outputs computed, no flush
    ex_set(1'b0, OP_BR, 3'd0, 32'h10, 32'd5, 32'd5, 32'h20, 1'b0, 32'd0);
    exp_push("inv_flush", S_FL, 32'h0);
    exp_push("inv_redir", S_RD, 32'h30);
    exp_push("inv_link", S_LK, 32'h14);
    step();
    exp_push("inv_pc", S_PC, 32'h14);
    exp_push("inv_cnt", S_CNT, 32'h7);
    // Mid-run reset with flush and stall pending
    rst = 1'b1; stall_i = 1'b1;
    ex_set(1'b1, OP_BR, 3'd0, 32'h10, 32'd5, 32'd5, 32'h20, 1'b0, 32'd0);
    exp_push("mrst_flush", S_FL, 32'h0);
    step();
    rst = 1'b0; stall_i = 1'b0; idle();
    for (int k = 0; k <= 8; k++) begin
      exp_push("post_rst_pc", S_PC, 32'(k * 4));
      if (k == 0) exp_push("post_rst_cnt", S_CNT, 32'h0);
      if (k == 8) exp_push("post_rst_pt20", S_PT, 32'h0);
      step();
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bpred_pc_unit.md
# bpred_pc_unit

Parametrised next-PC unit for the pipelined core: owns the fetch PC register, predicts control flow at fetch with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters, and resolves branches/jumps in EX. On a misprediction it flushes and redirects fetch. It supersedes the purely combinational next-PC logic and adds prediction, stall handling and a mispredict counter.

## Interface
- XLEN, 32: datapath and PC width.
- BTB_ENTRIES, 16: BTB depth; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold fetch PC; no effect on EX resolution.
- fetch_pc_o  out  XLEN  current fetch PC (register).
- pred_taken_o  out  1  prediction for fetch_pc_o.
- pred_target_o  out  XLEN  predicted next PC: BTB target if pred_taken_o, else fetch_pc_o+4.
- ex_valid_i  in  1  EX holds a valid instruction.
- ex_opcode_i  in  7, ex_funct3_i  in  3: EX instruction fields.
- ex_pc_i, ex_rs1_i, ex_rs2_i, ex_imm_i  in  XLEN each: EX PC, forwarded operands, sign-extended immediate.
- ex_pred_taken_i  in  1, ex_pred_target_i  in  XLEN: prediction carried down the pipe with the instruction.
- ex_link_o  out  XLEN  ex_pc_i+4 (rd write data for JAL/JALR).
- flush_o  out  1  mispredict; squash IF/ID.
- redirect_pc_o  out  XLEN  correct next PC of the EX instruction.
- mispredict_cnt_o  out  32  count of asserted flush_o cycles.

## Operation
- Lookup: index = fetch_pc_o[IDX+1:2], tag = fetch_pc_o[XLEN-1:IDX+2]. Hit = valid[index] && tag match. pred_taken_o = hit && ctr[index][1].
- Resolution (EX, combinational): opcode 1100011 is a branch. funct3 0 BEQ, 1 BNE, 4 BLT, 5 BGE (signed), 6 BLTU, 7 BGEU (unsigned); funct3 2/3 resolve not-taken. Branch target = ex_pc_i+ex_imm_i. 1101111 JAL: taken, target ex_pc_i+ex_imm_i. 1100111 JALR: taken, target (ex_rs1_i+ex_imm_i)&~1. Any other opcode: not taken. All sums modulo 2^XLEN.
- redirect_pc_o = actual_taken ? target : ex_pc_i+4.
- flush_o = ex_valid_i && !rst && (actual_taken != ex_pred_taken_i || (actual_taken && target != ex_pred_target_i)).
- PC update priority per edge: rst → RESET_PC; flush_o → redirect_pc_o (overrides stall_i); stall_i → hold; else pred_target_o.
- BTB update (edge, ex_valid_i && !rst, control opcode only), at ex_pc_i's index/tag:
  - Branch, entry hits: counter +1 if taken (saturate at 11), −1 if not (saturate at 00); target overwritten when taken.
  - Branch, miss, taken: allocate (overwrite): valid=1, tag, target, ctr=10. Miss, not taken: no change.
  - JAL/JALR: write valid=1, tag, target, ctr=11.
  - Non-control: no BTB change (may still flush if predicted taken).
- mispredict_cnt_o increments by 1 on each edge with flush_o=1; wraps at 2^32.

## Timing
- Reset values: fetch_pc_o=RESET_PC, all valid=0, all ctr=01, mispredict_cnt_o=0; hence pred_taken_o=0, pred_target_o=RESET_PC+4, flush_o=0.
- Lookup and resolution are combinational, zero cycle latency; state changes at next rising edge.
- Redirect latency: flush_o in cycle N ⇒ fetch_pc_o = redirect_pc_o in cycle N+1.
- Same-cycle lookup and update to one index: lookup returns pre-update contents; new contents visible from next cycle.
- rst mid-operation: all state returns to reset values on that edge regardless of flush/stall/ex_valid_i.
- ex_valid_i=0: ex_link_o/redirect_pc_o still computed, flush_o=0, no BTB or counter update.

## Test plan
- Reset: assert rst 1 cycle with ex_valid_i=1 and mispredict stimulus → fetch_pc_o=0, pred_taken_o=0, flush_o=0, counter 0; then with no stall, PC steps 0x0,0x4,0x8.
- BEQ cold miss: ex_pc_i=0x10, imm=0x20, rs1=rs2=5, pred_taken=0 → flush_o=1, redirect 0x30, next fetch_pc_o=0x30, counter=1; later fetch_pc_o=0x10 → pred_taken_o=1, pred_target_o=0x30.
- Counter saturation: resolve that BEQ not-taken twice (rs1=5, rs2=6) → first predicts taken (ctr 10→01, flush, redirect 0x14), then ctr 00 and stays 00 on a third not-taken; pred_taken_o=0 at 0x10.
- JALR: ex_pc_i=0x40, rs1=0x101, imm=0x4, pred_taken=1, pred_target=0x104 → no flush, ex_link_o=0x44; pred_target=0x100 → flush, redirect 0x104.
- Stall vs flush: stall_i=1 with flush_o=1 (BNE rs1=1, rs2=2, ex_pc 0x20, imm −8) → fetch_pc_o=0x18 next cycle; stall_i=1 alone → fetch_pc_o held.
- Signed/unsigned and aliasing: BLT rs1=0xFFFF_FFFF, rs2=1 taken, BLTU same not taken; ex_pc 0x10 and 0x50 (same index, different tag) → second allocation evicts first, fetch at 0x10 misses.
